// File: rtl/ifmap_window_mem_if.sv
// ifmap_window_mem_if: handshake bundle between a host and the ifmap window memory
//   cfg_*  : single-cycle configuration strobe (side N, filter K)
//   w_*    : write beat stream, one timestep plane at a time
//   rq_*   : window read request (top-left corner x,y and timestep)
//   rd_*   : registered window response
//   done_* : load-complete pulse with conv output side
//   err    : sticky error flag
interface ifmap_window_mem_if #(
  parameter int NUM_TS = 2,
  parameter int WORD_W = 36,
  parameter int MAX_K  = 5,
  parameter int TW     = (NUM_TS > 1) ? $clog2(NUM_TS) : 1
);
  logic                   cfg_valid;
  logic [5:0]             cfg_size;
  logic [2:0]             cfg_k;
  logic                   w_valid;
  logic                   w_ready;
  logic [WORD_W-1:0]      w_data;
  logic [TW-1:0]          w_ts;
  logic                   rq_valid;
  logic                   rq_ready;
  logic [5:0]             rq_x;
  logic [5:0]             rq_y;
  logic [TW-1:0]          rq_ts;
  logic                   rd_valid;
  logic                   rd_ready;
  logic [MAX_K*MAX_K-1:0] rd_data;
  logic                   done_valid;
  logic [5:0]             done_size;
  logic                   err;
  modport master (
    output cfg_valid, cfg_size, cfg_k, w_valid, w_data, w_ts,
           rq_valid, rq_x, rq_y, rq_ts, rd_ready,
    input  w_ready, rq_ready, rd_valid, rd_data, done_valid, done_size, err
  );
  modport slave (
    input  cfg_valid, cfg_size, cfg_k, w_valid, w_data, w_ts,
           rq_valid, rq_x, rq_y, rq_ts, rd_ready,
    output w_ready, rq_ready, rd_valid, rd_data, done_valid, done_size, err
  );
endinterface

// File: rtl/ifmap_window_mem.sv
// ifmap_window_mem: bit-per-cell ifmap store with per-timestep streaming load and KxK window reads
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : ifmap_window_mem_if.slave (cfg, write beats, window request/response, done, err)
module ifmap_window_mem #(
  parameter int MAX_SIZE = 38,
  parameter int NUM_TS   = 2,
  parameter int WORD_W   = 36,
  parameter int MAX_K    = 5
) (
  input logic               clk,
  input logic               rst_n,
  ifmap_window_mem_if.slave bus
);
  localparam int CELLS = MAX_SIZE * MAX_SIZE;
  localparam int CW    = $clog2(CELLS + 1);
  localparam int IW    = $clog2(CELLS);
  localparam int KK    = MAX_K * MAX_K;
  localparam int KI    = $clog2(KK);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  state_t            r_state;
  logic [5:0]        r_n;
  logic [2:0]        r_k;
  logic [CW-1:0]     r_cur [NUM_TS];
  logic [NUM_TS-1:0] r_cmp;
  logic [CELLS-1:0]  r_mem [NUM_TS];
  logic              r_rd_valid;
  logic [KK-1:0]     r_rd_data;
  logic              r_done_valid;
  logic [5:0]        r_done_size;
  logic              r_err;
  logic [CW-1:0]     w_nn;
  logic [CW-1:0]     w_cur;
  logic [CW-1:0]     w_rem;
  logic [CW-1:0]     w_step;
  logic [NUM_TS-1:0] w_cmp_nx;
  logic [KK-1:0]     w_win;
  logic              w_wts_ok;
  logic              w_wfire;
  logic              w_rfire;
  logic              w_oob;
  logic              w_cfg_ok;
  assign w_nn     = CW'(r_n) * CW'(r_n);
  assign w_wts_ok = int'(bus.w_ts) < NUM_TS;
  assign w_cur    = w_wts_ok ? r_cur[bus.w_ts] : '0;
  assign w_rem    = w_nn - w_cur;
  assign w_step   = (int'(w_rem) < WORD_W) ? w_rem : CW'(WORD_W);
  assign w_cfg_ok = int'(bus.cfg_k) >= 3 && int'(bus.cfg_k) <= MAX_K &&
                    bus.cfg_size >= {3'b0, bus.cfg_k} && int'(bus.cfg_size) <= MAX_SIZE;
  assign w_oob    = int'(bus.rq_x) + int'(r_k) > int'(r_n) ||
                    int'(bus.rq_y) + int'(r_k) > int'(r_n) ||
                    int'(bus.rq_ts) >= NUM_TS;
  assign bus.w_ready    = (r_state == LOAD) && w_wts_ok && !r_cmp[bus.w_ts];
  assign bus.rq_ready   = (r_state == READY) && (!r_rd_valid || bus.rd_ready);
  assign w_wfire        = bus.w_valid && bus.w_ready;
  assign w_rfire        = bus.rq_valid && bus.rq_ready;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_data    = r_rd_data;
  assign bus.done_valid = r_done_valid;
  assign bus.done_size  = r_done_size;
  assign bus.err        = r_err;
  // a plane completes when this beat moves its cursor exactly onto N*N
  always_comb begin
    w_cmp_nx = r_cmp;
    if (w_wfire && w_cur + w_step == w_nn) w_cmp_nx[bus.w_ts] = 1'b1;
  end
  // window bit dy*K+dx gathers cell (x+dx, y+dy); out-of-range requests read as zero
  always_comb begin
    w_win = '0;
    if (!w_oob)
      for (int dy = 0; dy < MAX_K; dy++)
        for (int dx = 0; dx < MAX_K; dx++)
          if (dy < int'(r_k) && dx < int'(r_k))
            w_win[KI'(dy * int'(r_k) + dx)] =
              r_mem[bus.rq_ts][IW'((int'(bus.rq_y) + dy) * int'(r_n) + int'(bus.rq_x) + dx)];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_k          <= '0;
      r_cmp        <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_done_valid <= 1'b0;
      r_done_size  <= '0;
      r_err        <= 1'b0;
      for (int t = 0; t < NUM_TS; t++) begin
        r_cur[t] <= '0;
        r_mem[t] <= '0;
      end
    end else begin
      r_done_valid <= 1'b0;
      if (bus.cfg_valid && r_state != LOAD) begin
        if (w_cfg_ok) begin
          r_state <= LOAD;
          r_n     <= bus.cfg_size;
          r_k     <= bus.cfg_k;
          r_cmp   <= '0;
          for (int t = 0; t < NUM_TS; t++) r_cur[t] <= '0;
        end else r_err <= 1'b1;
      end else if (w_wfire) begin
        r_cur[bus.w_ts] <= w_cur + w_step;
        r_cmp           <= w_cmp_nx;
        for (int b = 0; b < WORD_W; b++)
          if (int'(w_cur) + b < int'(w_nn)) r_mem[bus.w_ts][IW'(int'(w_cur) + b)] <= bus.w_data[b];
        if (&w_cmp_nx) begin
          r_state      <= READY;
          r_done_valid <= 1'b1;
          r_done_size  <= r_n - {3'b0, r_k} + 6'd1;
        end
      end
      if (w_rfire) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_win;
        if (w_oob) r_err <= 1'b1;
      end else if (bus.rd_ready) r_rd_valid <= 1'b0;
    end
endmodule

// File: tb/tb_ifmap_window_mem.sv
// tb_ifmap_window_mem: directed checks of load, window reads, backpressure, errors and reset
module tb_ifmap_window_mem;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  ifmap_window_mem_if #(.NUM_TS(2), .WORD_W(36), .MAX_K(5)) bus ();
  ifmap_window_mem #(.MAX_SIZE(38), .NUM_TS(2), .WORD_W(36), .MAX_K(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input int n, input int k);
    bus.cfg_valid = 1'b1;
    bus.cfg_size  = 6'(n);
    bus.cfg_k     = 3'(k);
    tick;
    bus.cfg_valid = 1'b0;
  endtask
  task automatic beat(input int ts, input logic [35:0] d);
    bus.w_valid = 1'b1;
    bus.w_ts    = 1'(ts);
    bus.w_data  = d;
    #1;
    chk("beat_wready", bus.w_ready, 1'b1);
    tick;
    bus.w_valid = 1'b0;
  endtask
  task automatic req(input int x, input int y, input int ts);
    bus.rq_valid = 1'b1;
    bus.rq_x     = 6'(x);
    bus.rq_y     = 6'(y);
    bus.rq_ts    = 1'(ts);
    #1;
    chk("req_ready", bus.rq_ready, 1'b1);
    tick;
    bus.rq_valid = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [24:0] exp);
    chk({tag, "_v"}, bus.rd_valid, 1'b1);
    chk(tag, bus.rd_data, exp);
  endtask
  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_size  = '0;
    bus.cfg_k     = '0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.w_ts      = '0;
    bus.rq_valid  = 1'b0;
    bus.rq_x      = '0;
    bus.rq_y      = '0;
    bus.rq_ts     = '0;
    bus.rd_ready  = 1'b1;
    #3;
    bus.w_valid  = 1'b1;
    bus.rq_valid = 1'b1;
    #1;
    chk("rst_wready", bus.w_ready, 1'b0);
    chk("rst_rqready", bus.rq_ready, 1'b0);
    chk("rst_rdvalid", bus.rd_valid, 1'b0);
    chk("rst_rddata", bus.rd_data, 25'h0);
    chk("rst_done", bus.done_valid, 1'b0);
    chk("rst_dsize", bus.done_size, 6'h0);
    chk("rst_err", bus.err, 1'b0);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_wready", bus.w_ready, 1'b0);
    chk("idle_rqready", bus.rq_ready, 1'b0);
    bus.w_valid  = 1'b0;
    bus.rq_valid = 1'b0;
    // first load: ts0 all ones, ts1 all zeros
    cfg(5, 3);
    beat(0, 36'h1FFFFFF);
    bus.w_ts = 1'b0;
    #1;
    chk("ts0_full_wready", bus.w_ready, 1'b0);
    bus.w_ts = 1'b1;
    #1;
    chk("ts1_open_wready", bus.w_ready, 1'b1);
    chk("early_done", bus.done_valid, 1'b0);
    beat(1, 36'h0);
    chk("done_pulse", bus.done_valid, 1'b1);
    chk("done_size3", bus.done_size, 6'd3);
    chk("ready_wready", bus.w_ready, 1'b0);
    tick;
    chk("done_one_cycle", bus.done_valid, 1'b0);
    req(0, 0, 0);
    rd_chk("win_ones", 25'h1FF);
    req(0, 0, 1);
    rd_chk("win_zeros", 25'h0);
    tick;
    chk("rdv_drop", bus.rd_valid, 1'b0);
    // reload: ts0 parity pattern (cell = x^y odd), ts1 all ones with excess bits
    cfg(5, 3);
    beat(0, 36'h0AAAAAA);
    beat(1, 36'hFFFFFFFFF);
    chk("done_pulse2", bus.done_valid, 1'b1);
    req(1, 2, 0);
    rd_chk("win_parity", 25'h155);
    tick;
    // backpressure: response held while rd_ready low
    bus.rd_ready = 1'b0;
    req(1, 2, 0);
    rd_chk("stall_first", 25'h155);
    bus.rq_valid = 1'b1;
    bus.rq_x     = 6'd2;
    bus.rq_y     = 6'd2;
    bus.rq_ts    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_rqready", bus.rq_ready, 1'b0);
      rd_chk("stall_hold", 25'h155);
      tick;
    end
    bus.rd_ready = 1'b1;
    #1;
    chk("unstall_rqready", bus.rq_ready, 1'b1);
    tick;
    rd_chk("b2b_0", 25'h0AA);
    bus.rq_x  = 6'd0;
    bus.rq_y  = 6'd0;
    bus.rq_ts = 1'b1;
    tick;
    rd_chk("b2b_1", 25'h1FF);
    bus.rq_y  = 6'd1;
    bus.rq_ts = 1'b0;
    tick;
    rd_chk("b2b_2", 25'h155);
    bus.rq_valid = 1'b0;
    tick;
    chk("b2b_drop", bus.rd_valid, 1'b0);
    chk("err_clean", bus.err, 1'b0);
    // out-of-range window
    req(3, 0, 0);
    rd_chk("oob_zero", 25'h0);
    chk("oob_err", bus.err, 1'b1);
    cfg(5, 3);
    chk("err_sticky", bus.err, 1'b1);
    // reset clears, then a rejected cfg (K > N) keeps IDLE and sets err
    rst_n = 1'b0;
    #1;
    chk("rst2_err", bus.err, 1'b0);
    chk("rst2_dsize", bus.done_size, 6'h0);
    rst_n = 1'b1;
    tick;
    cfg(3, 4);
    chk("badcfg_err", bus.err, 1'b1);
    bus.w_ts = 1'b0;
    #1;
    chk("badcfg_idle", bus.w_ready, 1'b0);
    // reset in the middle of an N=8 K=5 load
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick;
    cfg(8, 5);
    beat(0, 36'hFFFFFFFFF);
    #1;
    chk("partial_wready", bus.w_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midload_wready", bus.w_ready, 1'b0);
    chk("midload_err", bus.err, 1'b0);
    chk("midload_rdv", bus.rd_valid, 1'b0);
    rst_n = 1'b1;
    tick;
    // full reload: ts0 diagonal (cell = x==y), ts1 all ones
    cfg(8, 5);
    beat(0, 36'h008040201);
    beat(0, 36'h808040201);
    chk("n8_no_done", bus.done_valid, 1'b0);
    beat(1, 36'hFFFFFFFFF);
    beat(1, 36'hFFFFFFFFF);
    chk("n8_done", bus.done_valid, 1'b1);
    chk("n8_dsize", bus.done_size, 6'd4);
    req(0, 0, 0);
    rd_chk("n8_diag00", 25'h1041041);
    req(1, 0, 0);
    rd_chk("n8_diag10", 25'h0820820);
    req(3, 3, 0);
    rd_chk("n8_diag33", 25'h1041041);
    req(2, 1, 1);
    rd_chk("n8_ones", 25'h1FFFFFF);
    chk("n8_err_clean", bus.err, 1'b0);
    req(4, 0, 0);
    rd_chk("n8_oob", 25'h0);
    chk("n8_oob_err", bus.err, 1'b1);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ifmap_window_mem.md
IFMAP_WINDOW_MEM -- requirements
Module: ifmap_window_mem

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 38, maximum ifmap side N in cells.
REQ-002 SHALL have parameter NUM_TS, default 2, number of timestep planes stored.
REQ-003 SHALL have parameter WORD_W, default 36, ifmap bits carried per write beat.
REQ-004 SHALL have parameter MAX_K, default 5, largest filter side; supported K = 3..MAX_K.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have port cfg_valid  input  1  configuration strobe, single cycle.
REQ-008 SHALL have port cfg_size  input  6  ifmap side N.
REQ-009 SHALL have port cfg_k  input  3  filter side K.
REQ-010 SHALL have ports w_valid  input  1, w_ready  output  1, w_data  input  WORD_W, w_ts  input  $clog2(NUM_TS): write beat handshake.
REQ-011 SHALL have ports rq_valid  input  1, rq_ready  output  1, rq_x  input  6, rq_y  input  6, rq_ts  input  $clog2(NUM_TS): window read request.
REQ-012 SHALL have ports rd_valid  output  1, rd_ready  input  1, rd_data  output  MAX_K*MAX_K: window response.
REQ-013 SHALL have ports done_valid  output  1, done_size  output  6: load-complete notification and conv output side.
REQ-014 SHALL have port err  output  1  sticky error flag.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> READY; IDLE or READY + accepted cfg -> LOAD; LOAD ignores cfg_valid.
REQ-016 SHALL accept cfg only if K <= N <= MAX_SIZE and 3 <= K <= MAX_K; otherwise keep state and set err.
REQ-017 SHALL on accepted cfg latch N and K, zero every per-timestep cursor, and clear every per-timestep complete flag; memory contents are not cleared.
REQ-018 SHALL drive w_ready = (state==LOAD) && !complete[w_ts]; a beat transfers when w_valid && w_ready.
REQ-019 SHALL store w_data bit b, LSB first, to cell index cursor[w_ts]+b (row-major, x fastest: index = y*N+x) for every b with cursor+b < N*N; excess bits discarded.
REQ-020 SHALL advance cursor[w_ts] by min(WORD_W, N*N-cursor) and set complete[w_ts] when cursor reaches N*N.
REQ-021 SHALL, in the cycle after the last timestep plane completes, enter READY and pulse done_valid for exactly one cycle with done_size = N-K+1.
REQ-022 SHALL drive rq_ready = (state==READY) && (!rd_valid || rd_ready).
REQ-023 SHALL register the response: request accepted in cycle t -> rd_valid high from t+1 with rd_data bit (dy*K+dx) = mem[rq_ts][rq_y+dy][rq_x+dx] for dx,dy in 0..K-1; bits >= K*K zero.
REQ-024 SHALL hold rd_data and rd_valid stable while rd_valid && !rd_ready; rd_valid drops after a transfer unless a new request is accepted in the same cycle.
REQ-025 SHALL, for a request with rq_x+K > N or rq_y+K > N or rq_ts >= NUM_TS, return all-zero rd_data with normal timing and set err.
REQ-026 SHALL keep err high once set until reset; cfg does not clear err.
REQ-027 SHALL sustain one window read per cycle when rd_ready is held high.
REQ-028 SHALL NOT carry over a pending rd_valid across a new cfg; rd_valid still completes its handshake normally.

Reset
REQ-029 SHALL on rst_n low immediately force state IDLE, cursors 0, complete flags 0, memory all zero, w_ready 0, rq_ready 0, rd_valid 0, rd_data 0, done_valid 0, done_size 0, err 0.
REQ-030 SHALL on reset during LOAD or mid-read discard all progress; the first post-reset action requires a new cfg.

Verification
REQ-031 SHALL pass: rst_n low, then high -> all outputs 0, state IDLE; w_valid=1 -> w_ready stays 0.
REQ-032 SHALL pass: cfg N=5 K=3; ts0 beat w_data=0x1FFFFFF; ts1 beat w_data=0 -> w_ready drops per plane; done_valid one-cycle pulse with done_size=3.
REQ-033 SHALL pass: N=5, ts0 cell (x,y) = x^y parity pattern; request x=1 y=2 ts0 -> next-cycle rd_data matches computed 9-bit window, bits 24:9 zero.
REQ-034 SHALL pass: rd_ready low 3 cycles with rq_valid held -> rq_ready low, rd_data unchanged; rd_ready high -> back-to-back windows, one per cycle.
REQ-035 SHALL pass: N=5 K=3 request x=3 y=0 -> rd_data=0, err=1, err stays 1 through next valid cfg.
REQ-036 SHALL pass: reset asserted after first of two ts0 beats (N=8, K=5) -> outputs cleared; new cfg and full reload gives done_size=4 and correct windows.
